// File: rtl/servant_reset_seq_if.sv
// Sequencer-side bundle: lock and soft-reset requests in, sequenced domain resets and status out.
// The sequencer takes the master modport; whoever drives lock/soft-reset and consumes the resets takes slave.
interface servant_reset_seq_if #(
  parameter int NUM_OUT = 2
);
  logic               i_locked;
  logic               i_sw_rst;
  logic [NUM_OUT-1:0] o_rst;
  logic               o_ready;
  logic [7:0]         o_lost;

  modport master (
    input  i_locked,
    input  i_sw_rst,
    output o_rst,
    output o_ready,
    output o_lost
  );

  modport slave (
    output i_locked,
    output i_sw_rst,
    input  o_rst,
    input  o_ready,
    input  o_lost
  );
endinterface

// File: rtl/servant_reset_seq.sv
// Reset sequencer: synchronises PLL lock, filters it, stretches reset, then releases
// the reset domains in ascending order; lock loss or soft reset re-asserts every domain.
module servant_reset_seq #(
  parameter int NUM_OUT     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 8,
  parameter int STRETCH     = 16,
  parameter int STEP        = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  servant_reset_seq_if.master  bus
);

  localparam int REL_MAX = STEP * (NUM_OUT - 1);
  localparam int M1      = (LOCK_FILTER > STRETCH) ? LOCK_FILTER : STRETCH;
  localparam int CNT_MAX = (M1 > REL_MAX) ? M1 : REL_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_STRETCH,
    S_RELEASE,
    S_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_OUT-1:0]     rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [7:0]             lost_q, lost_d;

  logic                   locked_s;
  logic [CW-1:0]          cnt_inc;
  logic [NUM_OUT-1:0]     rel_hit;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign cnt_inc  = cnt_q + CW'(1);

  // Domain k is due when the post-release counter reaches STEP*k.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_rel
      assign rel_hit[gi] = (cnt_inc == CW'(STEP * gi));
    end
  endgenerate

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.i_locked};
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    lost_d  = lost_q;

    case (state_q)
      S_WAIT_LOCK: begin
        // Counter already holds LOCK_FILTER ones when the next one arrives.
        if (!locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(LOCK_FILTER)) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_STRETCH: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (bus.i_sw_rst) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(STRETCH - 1)) begin
          cnt_d    = '0;
          rst_d[0] = 1'b0;
          if (NUM_OUT == 1) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        // RELEASE and RUN share the abort paths; lock loss outranks soft reset.
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
          lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else if (bus.i_sw_rst) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end else if (state_q == S_RELEASE) begin
          cnt_d = cnt_inc;
          rst_d = rst_q & ~rel_hit;
          if (rel_hit[NUM_OUT-1]) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= '0;
      state_q <= S_WAIT_LOCK;
      cnt_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      lost_q  <= 8'd0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.o_rst   = rst_q;
  assign bus.o_ready = ready_q;
  assign bus.o_lost  = lost_q;

endmodule

// File: tb/tb_servant_reset_seq.sv
// Self-checking bench for servant_reset_seq: directed scenarios plus random lock/soft-reset
// traffic, all compared every cycle against a timestamp-based reference model.
module tb_servant_reset_seq;

  localparam int NUM_OUT     = 2;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_FILTER = 8;
  localparam int STRETCH     = 16;
  localparam int STEP        = 4;

  logic clk = 1'b0;
  logic rst;

  servant_reset_seq_if #(.NUM_OUT(NUM_OUT)) bus ();

  servant_reset_seq #(
    .NUM_OUT    (NUM_OUT),
    .SYNC_STAGES(SYNC_STAGES),
    .LOCK_FILTER(LOCK_FILTER),
    .STRETCH    (STRETCH),
    .STEP       (STEP)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the sequence is described by the edge at which stretching began
  // ("armed"); every domain release time follows from that timestamp arithmetically.
  bit samp_q[$];
  int armed  = -1;
  int ones   = 0;
  int lost_m = 0;
  int now    = 0;

  function automatic void model_reset();
    samp_q.delete();
    armed  = -1;
    ones   = 0;
    lost_m = 0;
  endfunction

  function automatic void model_edge(input bit locked_in, input bit sw_in);
    bit ls;
    now++;
    ls = (samp_q.size() == SYNC_STAGES) ? samp_q[0] : 1'b0;
    samp_q.push_back(locked_in);
    if (samp_q.size() > SYNC_STAGES) void'(samp_q.pop_front());
    if (!ls) begin
      if (armed >= 0 && (now - 1) >= armed + STRETCH && lost_m < 255) lost_m++;
      armed = -1;
      ones  = 0;
    end else begin
      ones++;
      if (armed < 0) begin
        if (ones == LOCK_FILTER + 1) armed = now;
      end else if (sw_in) begin
        armed = now;
      end
    end
  endfunction

  function automatic logic [NUM_OUT-1:0] exp_rst();
    logic [NUM_OUT-1:0] r;
    for (int k = 0; k < NUM_OUT; k++)
      r[k] = !(armed >= 0 && now >= armed + STRETCH + STEP * k);
    return r;
  endfunction

  function automatic logic exp_ready();
    return (armed >= 0 && now >= armed + STRETCH + STEP * (NUM_OUT - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(bus.i_locked, bus.i_sw_rst);
    #1;
    chk("model_o_rst", 32'(bus.o_rst), 32'(exp_rst()));
    chk("model_o_ready", 32'(bus.o_ready), 32'(exp_ready()));
    chk("model_o_lost", 32'(bus.o_lost), 32'(lost_m));
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_o_rst"}, 32'(bus.o_rst), 32'({NUM_OUT{1'b1}}));
    chk({tag, "_o_ready"}, 32'(bus.o_ready), 32'd0);
    chk({tag, "_o_lost"}, 32'(bus.o_lost), 32'd0);
    model_reset();
    #2 rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.i_locked = 1'b0;
    bus.i_sw_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o_rst", 32'(bus.o_rst), 32'b11);
    chk("reset_o_ready", 32'(bus.o_ready), 32'd0);
    chk("reset_o_lost", 32'(bus.o_lost), 32'd0);
    model_reset();
    #2 rst = 1'b0;
    repeat (3) step();

    // 1: lock held from cycle 0
    bus.i_locked = 1'b1;
    for (int c = 0; c <= 31; c++) begin
      step();
      if (c == 25) chk("t1_c25_rst", 32'(bus.o_rst), 32'b11);
      if (c == 26) chk("t1_c26_rst", 32'(bus.o_rst), 32'b10);
      if (c == 29) chk("t1_c29_ready", 32'(bus.o_ready), 32'd0);
      if (c == 30) chk("t1_c30_rst", 32'(bus.o_rst), 32'b00);
      if (c == 30) chk("t1_c30_ready", 32'(bus.o_ready), 32'd1);
    end
    chk("t1_lost", 32'(bus.o_lost), 32'd0);
    $display("test1: lock-to-release latency sequence done");

    // 2: lock glitch at cycle 5 restarts the filter
    bus.i_locked = 1'b0;
    do_reset("t2_rst");
    repeat (3) step();
    for (int c = 0; c <= 40; c++) begin
      bus.i_locked = (c != 5);
      step();
      if (c == 31) chk("t2_c31_rst", 32'(bus.o_rst), 32'b11);
      if (c == 32) chk("t2_c32_rst", 32'(bus.o_rst), 32'b10);
      if (c == 36) chk("t2_c36_rst", 32'(bus.o_rst), 32'b00);
    end
    chk("t2_lost", 32'(bus.o_lost), 32'd0);
    $display("test2: glitched lock sequence done");

    // 3: lock loss in RUN for 3 cycles
    for (int c = 0; c <= 35; c++) begin
      bus.i_locked = (c >= 3);
      step();
      if (c == 1) chk("t3_c1_rst", 32'(bus.o_rst), 32'b00);
      if (c == 2) chk("t3_c2_rst", 32'(bus.o_rst), 32'b11);
      if (c == 2) chk("t3_c2_ready", 32'(bus.o_ready), 32'd0);
      if (c == 2) chk("t3_c2_lost", 32'(bus.o_lost), 32'd1);
      if (c == 29) chk("t3_c29_rst", 32'(bus.o_rst), 32'b10);
      if (c == 33) chk("t3_c33_rst", 32'(bus.o_rst), 32'b00);
    end
    $display("test3: lock loss and resequence done");

    // 4: one-cycle soft reset in RUN
    for (int c = 0; c <= 22; c++) begin
      bus.i_sw_rst = (c == 0);
      step();
      if (c == 0) chk("t4_c0_rst", 32'(bus.o_rst), 32'b11);
      if (c == 15) chk("t4_c15_rst", 32'(bus.o_rst), 32'b11);
      if (c == 16) chk("t4_c16_rst", 32'(bus.o_rst), 32'b10);
      if (c == 19) chk("t4_c19_rst", 32'(bus.o_rst), 32'b10);
      if (c == 20) chk("t4_c20_rst", 32'(bus.o_rst), 32'b00);
    end
    chk("t4_lost", 32'(bus.o_lost), 32'd1);
    $display("test4: soft reset sequence done");

    // 5: soft reset coincident with synchronised lock loss
    for (int c = 0; c <= 35; c++) begin
      bus.i_locked = (c >= 2);
      bus.i_sw_rst = (c == 2);
      step();
      if (c == 2) chk("t5_c2_lost", 32'(bus.o_lost), 32'd2);
      if (c == 2) chk("t5_c2_rst", 32'(bus.o_rst), 32'b11);
    end
    for (int i = 0; i < 260; i++) begin
      bus.i_locked = 1'b0;
      step();
      bus.i_locked = 1'b1;
      repeat (30) step();
    end
    chk("t5_lost_sat", 32'(bus.o_lost), 32'd255);
    $display("test5: coincident abort and lost-count saturation done");

    // 6: async reset between domain releases
    for (int c = 0; c <= 27; c++) begin
      bus.i_locked = (c != 0);
      step();
      if (c == 27) chk("t6_c27_rst", 32'(bus.o_rst), 32'b10);
    end
    do_reset("t6_async");
    $display("test6: async reset mid-release done");

    // random lock drops, soft resets and async resets
    bus.i_locked = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      if (bus.i_locked) bus.i_locked = ($urandom_range(0, 99) >= 1);
      else              bus.i_locked = ($urandom_range(0, 99) < 40);
      bus.i_sw_rst = ($urandom_range(0, 99) < 2);
      step();
      if ($urandom_range(0, 999) < 3) begin
        do_reset("rand_async");
        $display("random: async reset at iteration %0d", it);
      end
    end
    bus.i_sw_rst = 1'b0;
    $display("random: traffic phase done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
